// File: rtl/riscv_pkg.sv
// Shared core constants and types: data width, register address width,
// and the hardwired-zero register index.
package riscv_pkg;

    localparam int XLEN       = 64;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port of the integer register file: address mux,
// x0 forced to zero, and (with REG_FILE_BYPASS_EN defined) a write-first
// bypass from the write port. Instantiated once per operand so both ports
// stay identical.
module reg_read_port
    import riscv_pkg::*;
#(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int NUM_REGS = riscv_pkg::NUM_REGS,
    parameter int ADDR_W   = riscv_pkg::REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   regs [NUM_REGS],
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]   write_data,
    output logic [XLEN-1:0]   read_data
);

`ifndef REG_FILE_BYPASS_EN
    // Write-port signals only matter to the bypass; fold them away otherwise.
    logic unused_wr;
    assign unused_wr = ^{reset, reg_write, rd_addr, write_data};
`endif

    // Select the addressed entry; x0 always reads zero, bypass overrides when enabled.
    always_comb begin
        read_data = '0;
        if (addr != ADDR_W'(REG_ZERO)) begin
            read_data = regs[addr];
`ifdef REG_FILE_BYPASS_EN
            // addr is non-zero here, so a match implies rd_addr is non-zero too.
            if (!reset && reg_write && (rd_addr == addr)) begin
                read_data = write_data;
            end
`endif
        end
    end

endmodule

// File: rtl/reg_file.sv
// Integer register file: 32 x XLEN registers, two combinational read ports,
// one synchronous write port, x0 hardwired to zero. Synchronous active-high
// reset clears every entry and discards a coincident write.
// Optional macro REG_FILE_BYPASS_EN adds a write-first bypass on both reads.
// There is no handshake: the core holds rd_addr/write_data/reg_write stable
// before each rising edge, and reads are pure functions of address and state.
module reg_file
    import riscv_pkg::*;
#(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int NUM_REGS = riscv_pkg::NUM_REGS,
    parameter int ADDR_W   = riscv_pkg::REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   read_data1,
    output logic [XLEN-1:0]   read_data2,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]   write_data
);

    logic [XLEN-1:0] regs [NUM_REGS];

    // Storage update: reset clears all entries; otherwise write rd_addr unless it is x0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write && (rd_addr != ADDR_W'(REG_ZERO))) begin
            regs[rd_addr] <= write_data;
        end
    end

    reg_read_port #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_rd_port1 (
        .addr       (rs1_addr),
        .regs       (regs),
        .reset      (reset),
        .reg_write  (reg_write),
        .rd_addr    (rd_addr),
        .write_data (write_data),
        .read_data  (read_data1)
    );

    reg_read_port #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_rd_port2 (
        .addr       (rs2_addr),
        .regs       (regs),
        .reset      (reset),
        .reg_write  (reg_write),
        .rd_addr    (rd_addr),
        .write_data (write_data),
        .read_data  (read_data2)
    );

endmodule
